// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low hex font, segment bit positions,
// scan FSM states and the per-digit record.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Indexed by hex value, {dp,g,f,e,d,c,b,a} active low, dp held dark
  localparam logic [15:0][7:0] SEG_FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic {BLANK, SHOW} scan_state_t;

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       on;
  } digit_t;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Digit write port between user logic (master) and the scan controller (slave).
interface seg7_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic          wr_valid;
  logic          wr_ready;
  logic [IW-1:0] wr_digit;
  logic [3:0]    wr_value;
  logic          wr_dp;
  logic          wr_on;

  modport master (output wr_valid, wr_digit, wr_value, wr_dp, wr_on, input wr_ready);
  modport slave  (input wr_valid, wr_digit, wr_value, wr_dp, wr_on, output wr_ready);

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational {value, dp, on} to active-low segment pattern; unlit digits go dark.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_value,
  input  logic       i_dp,
  input  logic       i_on,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    if (i_on) begin
      o_seg         = SEG_FONT[i_value];
      o_seg[SEG_DP] = ~i_dp;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller: shadow/active banks with frame-boundary
// commit, per-slot anti-ghosting blank, all outputs registered.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter  int DIGITS       = 4,
  parameter  int TICK_CYCLES  = 100000,
  parameter  int BLANK_CYCLES = 1000,
  localparam int IW           = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CW           = $clog2(TICK_CYCLES)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  seg7_scan_ctrl_if.slave   wr,
  output logic [7:0]        io_seg,
  output logic [DIGITS-1:0] io_sel,
  output logic [IW-1:0]     scan_idx,
  output logic              frame_done
);

  scan_state_t            r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [IW-1:0]          w_idx_nxt;
  digit_t [DIGITS-1:0]    r_shd, r_act, w_act_nxt;
  digit_t                 w_cur, w_wr_dig;
  logic                   w_wrap, w_fd_nxt, w_commit, w_wr_fire;
  logic [7:0]             w_dec, w_seg_nxt;
  logic [DIGITS-1:0]      w_sel_nxt;

  assign w_wrap = (r_cnt == CW'(TICK_CYCLES - 1));

  always_comb begin
    w_cnt_nxt = '0;
    w_idx_nxt = '0;
    if (enable) begin
      w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
      w_idx_nxt = scan_idx;
      if (w_wrap)
        w_idx_nxt = (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  // Outputs are registered against the next counter state so they line up with it
  assign w_fd_nxt = enable && (w_idx_nxt == IW'(DIGITS - 1)) &&
                    (w_cnt_nxt == CW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BLANK;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = BLANK;
    end else begin
      case (r_state)
        BLANK:   if (r_cnt == CW'(BLANK_CYCLES - 1)) w_state_nxt = SHOW;
        SHOW:    if (w_wrap) w_state_nxt = BLANK;
        default: w_state_nxt = BLANK;
      endcase
    end
  end

  // Active bank only moves at the frame boundary, or continuously while disabled
  assign w_commit  = !enable || frame_done;
  assign w_act_nxt = w_commit ? r_shd : r_act;
  assign w_wr_fire = wr.wr_valid && wr.wr_ready;
  assign w_wr_dig  = '{value: wr.wr_value, dp: wr.wr_dp, on: wr.wr_on};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shd <= '0;
      r_act <= '0;
    end else begin
      r_act <= w_act_nxt;
      for (int d = 0; d < DIGITS; d++)
        if (w_wr_fire && wr.wr_digit == IW'(d)) r_shd[d] <= w_wr_dig;
    end
  end

  assign w_cur = w_act_nxt[w_idx_nxt];

  seg7_hex_decode u_dec (
    .i_value (w_cur.value),
    .i_dp    (w_cur.dp),
    .i_on    (w_cur.on),
    .o_seg   (w_dec)
  );

  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_sel_nxt = '1;
    if (w_state_nxt == SHOW && w_cur.on) begin
      w_seg_nxt            = w_dec;
      w_sel_nxt[w_idx_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      scan_idx    <= '0;
      frame_done  <= 1'b0;
      io_seg      <= SEG_OFF;
      io_sel      <= '1;
      wr.wr_ready <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      scan_idx    <= w_idx_nxt;
      frame_done  <= w_fd_nxt;
      io_seg      <= w_seg_nxt;
      io_sel      <= w_sel_nxt;
      wr.wr_ready <= !w_fd_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random traffic, all checked
// against a frame-position model of the display.
module tb_seg7_scan_ctrl;

  localparam int D = 4, T = 8, B = 2, F = D * T;

  logic       clk = 0, rst_n = 0, enable = 0;
  logic [7:0] io_seg;
  logic [3:0] io_sel;
  logic [1:0] scan_idx;
  logic       frame_done;

  seg7_scan_ctrl_if #(.DIGITS(D)) wr();

  seg7_scan_ctrl #(.DIGITS(D), .TICK_CYCLES(T), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr),
    .io_seg(io_seg), .io_sel(io_sel), .scan_idx(scan_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // active-high gfedcba hex glyphs
  logic [6:0] HI [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {bit [3:0] v; bit dp; bit on;} mdig_t;
  mdig_t      m_shd [D], m_act [D];
  int         m_p, e_idx;
  bit         m_ready, m_fd;
  logic [7:0] e_seg;
  logic [3:0] e_sel;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_shd[i] = '{0, 0, 0};
      m_act[i] = '{0, 0, 0};
    end
    m_p = 0; m_ready = 0; m_fd = 0;
    e_seg = 8'hFF; e_sel = 4'hF; e_idx = 0;
  endtask

  // m_p = cycles elapsed in the current frame since scanning (re)started
  task automatic model_edge(input bit en, wv, input bit [1:0] wd, input bit [3:0] wval,
                            input bit wdp, won);
    bit acc, commit;
    int slot, off;
    acc    = wv && m_ready;
    commit = !en || m_fd;
    if (commit) m_act = m_shd;
    if (acc && wd < D) m_shd[wd] = '{wval, wdp, won};
    m_p     = en ? (m_p + 1) % F : 0;
    m_fd    = en && (m_p == F - 1);
    m_ready = !m_fd;
    slot = m_p / T;
    off  = m_p % T;
    e_idx = slot; e_seg = 8'hFF; e_sel = 4'hF;
    if (off >= B && m_act[slot].on) begin
      e_sel = ~(4'b0001 << slot);
      e_seg = {~m_act[slot].dp, ~HI[m_act[slot].v]};
    end
  endtask

  task automatic check_all();
    chk("seg", io_seg, e_seg);
    chk("sel", io_sel, e_sel);
    chk("idx", scan_idx, e_idx);
    chk("fd", frame_done, m_fd);
    chk("rdy", wr.wr_ready, m_ready);
  endtask

  task automatic step(input bit en, wv, input bit [1:0] wd, input bit [3:0] wval,
                      input bit wdp, won);
    @(negedge clk);
    enable = en; wr.wr_valid = wv; wr.wr_digit = wd;
    wr.wr_value = wval; wr.wr_dp = wdp; wr.wr_on = won;
    @(posedge clk);
    model_edge(en, wv, wd, wval, wdp, won);
    #1 check_all();
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 2 * F && !frame_done; i++) idle();
    chk("fd_wait", frame_done, 1);
  endtask

  task automatic run_to(input int slot, input int off);
    for (int i = 0; i < 2 * F && m_p != slot * T + off; i++) idle();
    chk("run_to", scan_idx, slot);
  endtask

  initial begin
    int n_fd, n_lit;
    wr.wr_valid = 0; wr.wr_digit = 0; wr.wr_value = 0; wr.wr_dp = 0; wr.wr_on = 0;
    model_reset();

    // 1: reset and idle frames
    enable = 1;
    repeat (3) begin @(posedge clk); #1 check_all(); end
    #1 rst_n = 1;
    #1 chk("rdy_rel", wr.wr_ready, 0);
    n_fd = 0;
    repeat (64) begin idle(); n_fd += int'(frame_done); end
    chk("fd_cnt", n_fd, 2);

    // 2: digit0 = 3
    step(1, 1, 0, 4'h3, 0, 1);
    wait_fd();
    for (int k = 0; k < T; k++) begin
      idle();
      chk("t2_seg", io_seg, k < B ? 8'hFF : 8'hB0);
      chk("t2_sel", io_sel, k < B ? 4'hF : 4'hE);
    end
    for (int k = 0; k < 3 * T; k++) begin idle(); chk("t2_dark", io_sel, 4'hF); end

    // 3: digit2 = F with dp
    idle();
    step(1, 1, 2, 4'hF, 1, 1);
    wait_fd();
    repeat (2 * T) idle();
    for (int k = 0; k < T; k++) begin
      idle();
      chk("t3_idx", scan_idx, 2);
      chk("t3_seg", io_seg, k < B ? 8'hFF : 8'h0E);
      chk("t3_sel", io_sel, k < B ? 4'hF : 4'hB);
    end

    // 4: no tearing, commit stall, write just before frame_done
    wait_fd();
    repeat (3) idle();
    step(1, 1, 0, 4'h5, 0, 1);
    for (int k = 0; k < 4; k++) begin idle(); chk("t4_old", io_seg, 8'hB0); end
    wait_fd();
    repeat (3) idle();
    chk("t4_new", io_seg, 8'h92);
    wait_fd();
    chk("t4_rdy0", wr.wr_ready, 0);
    step(1, 1, 1, 4'h7, 0, 1);
    chk("t4_rdy1", wr.wr_ready, 1);
    step(1, 1, 1, 4'h7, 0, 1);
    run_to(1, 3);
    chk("t4_notyet", io_seg, 8'hFF);
    wait_fd();
    run_to(1, 3);
    chk("t4_held_seg", io_seg, 8'hF8);
    chk("t4_held_sel", io_sel, 4'hD);
    run_to(3, 6);
    step(1, 1, 3, 4'h8, 0, 1);
    run_to(3, 3);
    chk("t4_late_seg", io_seg, 8'h80);
    chk("t4_late_sel", io_sel, 4'h7);

    // 5: enable drop during digit1 SHOW, then restore
    run_to(1, 4);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_idx", scan_idx, 0);
    chk("t5_seg", io_seg, 8'hFF);
    chk("t5_sel", io_sel, 4'hF);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("t5_dark", io_sel, 4'hF);
    idle();
    chk("t5_lit_seg", io_seg, 8'h92);
    chk("t5_lit_sel", io_sel, 4'hE);

    // 6: asynchronous reset pulse while lit
    run_to(0, 4);
    chk("t6_pre", io_sel, 4'hE);
    #1 rst_n = 0;
    #1 chk("t6_seg", io_seg, 8'hFF);
    chk("t6_sel", io_sel, 4'hF);
    chk("t6_rdy", wr.wr_ready, 0);
    rst_n = 1;
    model_reset();
    #1 check_all();
    n_lit = 0;
    repeat (2 * F) begin idle(); n_lit += int'(io_sel != 4'hF); end
    chk("t6_dark", n_lit, 0);

    // 7: random traffic
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
